// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer sharing one asynchronous SRAM
// between two req/ack ports; all outputs are registered.
module sram_arbiter #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESB,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    output logic [7:0]        a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    output logic              sram_doe,
    input  logic [7:0]        sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic        GRANT_A = 1'b0;
    localparam logic        GRANT_B = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic              last_grant, last_grant_d;
    logic              grant, grant_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              pick_b;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        dout_d, a_rdata_d, b_rdata_d;
    logic              doe_d, ce_n_d, oe_n_d, we_n_d, a_ack_d, b_ack_d, busy_d;

    // State and all outputs; sram_addr/sram_dout double as the latched request.
    always_ff @(posedge CLK) begin
        if (!RESB) begin
            state      <= S_IDLE;
            last_grant <= GRANT_B;
            grant      <= GRANT_A;
            cnt        <= '0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            sram_doe   <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            grant      <= grant_d;
            cnt        <= cnt_d;
            sram_addr  <= addr_d;
            sram_dout  <= dout_d;
            sram_doe   <= doe_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            a_ack      <= a_ack_d;
            b_ack      <= b_ack_d;
            a_rdata    <= a_rdata_d;
            b_rdata    <= b_rdata_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        grant_d      = grant;
        cnt_d        = cnt;
        addr_d       = sram_addr;
        dout_d       = sram_dout;
        doe_d        = sram_doe;
        ce_n_d       = sram_ce_n;
        oe_n_d       = sram_oe_n;
        we_n_d       = sram_we_n;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata;
        b_rdata_d    = b_rdata;
        // B wins when alone, or on a tie when A was served last.
        pick_b       = b_req && (!a_req || (last_grant == GRANT_A));

        case (state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    grant_d      = pick_b;
                    last_grant_d = pick_b;
                    ce_n_d       = 1'b0;
                    addr_d       = pick_b ? b_addr : a_addr;
                    if (pick_b ? b_we : a_we) begin
                        state_d = S_WSETUP;
                        doe_d   = 1'b1;
                        dout_d  = pick_b ? b_wdata : a_wdata;
                    end else begin
                        state_d = S_READ;
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_W'(RD_CYCLES - 1);
                    end
                end
            end
            S_READ: begin
                if (cnt == '0) begin
                    state_d = S_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (grant == GRANT_B) begin
                        b_rdata_d = sram_din;
                        b_ack_d   = 1'b1;
                    end else begin
                        a_rdata_d = sram_din;
                        a_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = CNT_W'(WR_CYCLES - 1);
            end
            S_WPULSE: begin
                if (cnt == '0) begin
                    state_d = S_WHOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_WHOLD: begin
                state_d = S_DONE;
                ce_n_d  = 1'b1;
                doe_d   = 1'b0;
                a_ack_d = (grant == GRANT_A);
                b_ack_d = (grant == GRANT_B);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
